// File: rtl/vx_ipdom_ctrl_if.sv
// Request/response channel between the issue/branch stage, the IPDOM controller and the warp scheduler.
interface vx_ipdom_ctrl_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned PC_WIDTH    = 32
);
  localparam int unsigned WIDW = $clog2(NUM_WARPS);

  logic                   req_valid;
  logic                   req_ready;
  logic [WIDW-1:0]        req_wid;
  logic                   req_is_split;
  logic [NUM_THREADS-1:0] req_then_tmask;
  logic [NUM_THREADS-1:0] req_else_tmask;
  logic [PC_WIDTH-1:0]    req_else_pc;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDW-1:0]        rsp_wid;
  logic [NUM_THREADS-1:0] rsp_tmask;
  logic                   rsp_redirect;
  logic [PC_WIDTH-1:0]    rsp_pc;

  modport master (
    output req_valid, req_wid, req_is_split, req_then_tmask, req_else_tmask, req_else_pc,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_wid, rsp_tmask, rsp_redirect, rsp_pc
  );

  modport slave (
    input  req_valid, req_wid, req_is_split, req_then_tmask, req_else_tmask, req_else_pc,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_wid, rsp_tmask, rsp_redirect, rsp_pc
  );
endinterface

// File: rtl/vx_ipdom_ctrl.sv
// Split/join sequencer driving per-warp IPDOM stacks; registered join response,
// per-warp pending-join counters and sticky overflow/underflow flags.
module vx_ipdom_ctrl #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned DEPTH       = 8,
  localparam int unsigned WIDW = $clog2(NUM_WARPS),
  localparam int unsigned ENTW = NUM_THREADS + PC_WIDTH,
  localparam int unsigned CNTW = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  vx_ipdom_ctrl_if.slave                 io,
  output logic [NUM_WARPS-1:0]           stk_push,
  output logic [NUM_WARPS-1:0]           stk_pop,
  output logic                           stk_pair,
  output logic [ENTW-1:0]                stk_q1,
  output logic [ENTW-1:0]                stk_q2,
  input  logic [NUM_WARPS-1:0][ENTW-1:0] stk_d,
  input  logic [NUM_WARPS-1:0]           stk_index,
  input  logic [NUM_WARPS-1:0]           stk_empty,
  input  logic [NUM_WARPS-1:0]           stk_full,
  output logic [NUM_WARPS-1:0][CNTW-1:0] pending,
  output logic [NUM_WARPS-1:0]           err_ovf,
  output logic [NUM_WARPS-1:0]           err_udf,
  input  logic [NUM_WARPS-1:0]           err_clear
);

  logic                           r_rsp_valid;
  logic [WIDW-1:0]                r_rsp_wid;
  logic [NUM_THREADS-1:0]         r_rsp_tmask;
  logic                           r_rsp_redirect;
  logic [PC_WIDTH-1:0]            r_rsp_pc;
  logic [NUM_WARPS-1:0][CNTW-1:0] r_pending;
  logic [NUM_WARPS-1:0]           r_err_ovf;
  logic [NUM_WARPS-1:0]           r_err_udf;

  logic                   w_req_ready;
  logic                   w_fire;
  logic                   w_split;
  logic                   w_join;
  logic                   w_divergent;
  logic                   w_push_ok;
  logic                   w_pop_ok;
  logic [NUM_WARPS-1:0]   w_wid_oh;
  logic [CNTW-1:0]        w_cur_pend;
  logic [ENTW-1:0]        w_top;
  logic [NUM_THREADS-1:0] w_rsp_tmask;
  logic                   w_rsp_redirect;
  logic [PC_WIDTH-1:0]    w_rsp_pc;
  logic [NUM_WARPS-1:0]   w_ovf_set;
  logic [NUM_WARPS-1:0]   w_udf_set;

  // Single output register: accept whenever the held response drains this cycle.
  assign w_req_ready = !reset && (!r_rsp_valid || io.rsp_ready);
  assign w_fire      = io.req_valid && w_req_ready;
  assign w_split     = w_fire && io.req_is_split;
  assign w_join      = w_fire && !io.req_is_split;
  assign w_wid_oh    = NUM_WARPS'(1) << io.req_wid;
  assign w_cur_pend  = r_pending[io.req_wid];
  assign w_top       = stk_d[io.req_wid];

  assign w_divergent = (|io.req_then_tmask) && (|io.req_else_tmask);
  assign w_push_ok   = w_split && !stk_full[io.req_wid];
  assign w_pop_ok    = w_join && (w_cur_pend != '0) && !stk_empty[io.req_wid];

  // Stack write port: q1 is the reconvergence entry, q2 the else-path entry.
  always_comb begin
    stk_push = '0;
    stk_pop  = '0;
    stk_pair = 1'b0;
    stk_q1   = {io.req_then_tmask | io.req_else_tmask, PC_WIDTH'(0)};
    stk_q2   = {io.req_else_tmask, io.req_else_pc};
    if (w_push_ok) begin
      stk_push = w_wid_oh;
      stk_pair = w_divergent;
    end else if (w_pop_ok) begin
      stk_pop = w_wid_oh;
    end
  end

  // Index 0 marks the else-path half of a pair: redirect; index 1 reconverges.
  always_comb begin
    w_rsp_tmask    = '0;
    w_rsp_redirect = 1'b0;
    w_rsp_pc       = '0;
    if (w_pop_ok) begin
      w_rsp_tmask    = w_top[ENTW-1 -: NUM_THREADS];
      w_rsp_redirect = !stk_index[io.req_wid];
      if (!stk_index[io.req_wid]) begin
        w_rsp_pc = w_top[PC_WIDTH-1:0];
      end
    end
  end

  assign w_ovf_set = (w_split && !w_push_ok) ? w_wid_oh : '0;
  assign w_udf_set = (w_join && !w_pop_ok) ? w_wid_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_wid      <= '0;
      r_rsp_tmask    <= '0;
      r_rsp_redirect <= 1'b0;
      r_rsp_pc       <= '0;
      r_pending      <= '0;
      r_err_ovf      <= '0;
      r_err_udf      <= '0;
    end else begin
      if (w_join) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_wid      <= io.req_wid;
        r_rsp_tmask    <= w_rsp_tmask;
        r_rsp_redirect <= w_rsp_redirect;
        r_rsp_pc       <= w_rsp_pc;
      end else if (io.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        if (w_push_ok && (io.req_wid == WIDW'(w))) begin
          r_pending[w] <= r_pending[w] + (w_divergent ? CNTW'(2) : CNTW'(1));
        end else if (w_pop_ok && (io.req_wid == WIDW'(w))) begin
          r_pending[w] <= r_pending[w] - CNTW'(1);
        end
      end

      // A same-cycle set takes priority over the clear.
      r_err_ovf <= (r_err_ovf & ~err_clear) | w_ovf_set;
      r_err_udf <= (r_err_udf & ~err_clear) | w_udf_set;
    end
  end

  assign io.req_ready    = w_req_ready;
  assign io.rsp_valid    = r_rsp_valid;
  assign io.rsp_wid      = r_rsp_wid;
  assign io.rsp_tmask    = r_rsp_tmask;
  assign io.rsp_redirect = r_rsp_redirect;
  assign io.rsp_pc       = r_rsp_pc;
  assign pending         = r_pending;
  assign err_ovf         = r_err_ovf;
  assign err_udf         = r_err_udf;

endmodule
